// File: rtl/demux_4s_reg_pkg.sv
// Shared constants for the registered 1-to-4 demultiplexer.
// Defines the output count, select width, counter width and slot state encodings.
// Imported by demux_slot and demux_4s_reg.
package demux_4s_reg_pkg;

  localparam int N_OUT = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  // One-entry slot states.
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

endpackage

// File: rtl/demux_slot.sv
// One output slot of the demux: data register, valid flag, optional transfer counter.
// Latency: a loaded word is visible on q/vld one cycle after the load edge.
// Backpressure: holds its word until take is seen with vld high; a load may replace it on the same edge.
// Ports: load (input transfer addressed here), d (word to load), take (consumer ready),
//        q/vld (slot contents), cnt (output transfer count, only with DEMUX_CNT_EN).
module demux_slot
  import demux_4s_reg_pkg::*;
#(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             load,
  input  logic [width-1:0] d,
  input  logic             take,
  output logic [width-1:0] q,
  output logic             vld
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);

  logic [0:0] state;
  logic       drain;

  assign vld   = (state == FULL);
  // A take while EMPTY is not a transfer and must be ignored.
  assign drain = vld && take;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= EMPTY;
      q     <= '0;
    end else if (load) begin
      // Covers both EMPTY->FULL and the simultaneous drain+refill case.
      state <= FULL;
      q     <= d;
    end else if (drain) begin
      // Data is left in place; consumers qualify q with vld.
      state <= EMPTY;
    end
  end

`ifdef DEMUX_CNT_EN
  // Wraps 255 -> 0 naturally.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (drain) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/demux_4s_reg.sv
// Registered 1-to-4 demultiplexer with a one-entry slot per output (optional counters: DEMUX_CNT_EN).
// Latency: one cycle from input accept to the word appearing on its output.
// Backpressure: in_ready drops only when the selected slot is FULL and its consumer is not ready.
// Ports: d/s/in_valid/in_ready input handshake; o0..o3 with o_valid/o_ready per output;
//        cnt_flat = four 8-bit transfer counters (output k at [8k+7:8k]), only with DEMUX_CNT_EN.
module demux_4s_reg
  import demux_4s_reg_pkg::*;
#(
  parameter int width = 4
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic [width-1:0]       d,
  input  logic [SEL_W-1:0]       s,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [width-1:0]       o0,
  output logic [width-1:0]       o1,
  output logic [width-1:0]       o2,
  output logic [width-1:0]       o3,
  output logic [N_OUT-1:0]       o_valid,
  input  logic [N_OUT-1:0]       o_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [N_OUT*CNT_W-1:0] cnt_flat
`endif
);

  logic [width-1:0] q [N_OUT];
  logic             in_xfer;

  // Selected slot can take a word if empty, or if it drains on this same edge.
  assign in_ready = !o_valid[s] || o_ready[s];
  assign in_xfer  = in_valid && in_ready;

  genvar k;
  generate
    for (k = 0; k < N_OUT; k++) begin : g_slot
      demux_slot #(
        .width(width)
      ) u_slot (
        .clk  (clk),
        .rst_b(rst_b),
        .load (in_xfer && (s == SEL_W'(k))),
        .d    (d),
        .take (o_ready[k]),
        .q    (q[k]),
        .vld  (o_valid[k])
`ifdef DEMUX_CNT_EN
        ,
        .cnt  (cnt_flat[CNT_W*k +: CNT_W])
`endif
      );
    end
  endgenerate

  assign o0 = q[0];
  assign o1 = q[1];
  assign o2 = q[2];
  assign o3 = q[3];

endmodule

// File: tb/tb_demux_4s_reg.sv
// Self-checking bench for demux_4s_reg: directed table, hand sequences, random traffic vs a slot model.
// Inputs are driven at the falling edge; in_ready is sampled just before the rising edge, outputs after it.
// Counter checks are compiled in only when DEMUX_CNT_EN is defined.
module tb_demux_4s_reg;

  logic       clk;
  logic       rst_b;
  logic [3:0] d;
  logic [1:0] s;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] o0, o1, o2, o3;
  logic [3:0] o_valid;
  logic [3:0] o_ready;
`ifdef DEMUX_CNT_EN
  logic [31:0] cnt_flat;
`endif

  demux_4s_reg #(.width(4)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .d       (d),
    .s       (s),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .o0      (o0),
    .o1      (o1),
    .o2      (o2),
    .o3      (o3),
    .o_valid (o_valid),
    .o_ready (o_ready)
`ifdef DEMUX_CNT_EN
    ,
    .cnt_flat(cnt_flat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one buffered word per output, plus delivery counts.
  logic       m_vld [4];
  logic [3:0] m_dat [4];
  int         m_cnt [4];
  logic       act_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_vld[k] = 1'b0;
      m_dat[k] = 4'h0;
      m_cnt[k] = 0;
    end
  endtask

  task automatic cmp_model();
    chk("o_valid", {28'h0, o_valid}, {28'h0, m_vld[3], m_vld[2], m_vld[1], m_vld[0]});
    chk("o0", {28'h0, o0}, {28'h0, m_dat[0]});
    chk("o1", {28'h0, o1}, {28'h0, m_dat[1]});
    chk("o2", {28'h0, o2}, {28'h0, m_dat[2]});
    chk("o3", {28'h0, o3}, {28'h0, m_dat[3]});
`ifdef DEMUX_CNT_EN
    for (int k = 0; k < 4; k++)
      chk("cnt", {24'h0, cnt_flat[8*k +: 8]}, 32'(m_cnt[k] % 256));
`endif
  endtask

  // One cycle: called at a falling edge, returns at the next falling edge.
  task automatic step(input logic v, input logic [1:0] sel, input logic [3:0] dat, input logic [3:0] ordy);
    logic exp_rdy;
    in_valid = v;
    s        = sel;
    d        = dat;
    o_ready  = ordy;
    #1;
    exp_rdy = !m_vld[sel] || ordy[sel];
    act_rdy = in_ready;
    chk("in_ready", {31'h0, in_ready}, {31'h0, exp_rdy});
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (m_vld[k] && ordy[k]) begin
        m_vld[k] = 1'b0;
        m_cnt[k]++;
      end
    end
    if (v && exp_rdy) begin
      m_vld[sel] = 1'b1;
      m_dat[sel] = dat;
    end
    @(negedge clk);
    cmp_model();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    s        = 2'b00;
    d        = 4'h0;
    o_ready  = 4'b0000;
    rst_b    = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [3:0]  dat;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_vld;
    logic [15:0] exp_o;   // {o3,o2,o1,o0} after the edge
  } vec_t;

  vec_t tbl [10];

  initial begin
    #1000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    // fill all slots, backpressure on slot 2, then drains and a simultaneous refill
    tbl[0] = '{1'b1, 2'd0, 4'h1, 4'b0000, 1'b1, 4'b0001, 16'h0001};
    tbl[1] = '{1'b1, 2'd1, 4'h2, 4'b0000, 1'b1, 4'b0011, 16'h0021};
    tbl[2] = '{1'b1, 2'd2, 4'h4, 4'b0000, 1'b1, 4'b0111, 16'h0421};
    tbl[3] = '{1'b1, 2'd3, 4'h8, 4'b0000, 1'b1, 4'b1111, 16'h8421};
    tbl[4] = '{1'b1, 2'd2, 4'hF, 4'b0000, 1'b0, 4'b1111, 16'h8421};
    tbl[5] = '{1'b1, 2'd2, 4'hF, 4'b0100, 1'b1, 4'b1111, 16'h8F21};
    tbl[6] = '{1'b0, 2'd0, 4'h0, 4'b0001, 1'b1, 4'b1110, 16'h8F21};
    tbl[7] = '{1'b0, 2'd0, 4'h0, 4'b0001, 1'b1, 4'b1110, 16'h8F21};
    tbl[8] = '{1'b1, 2'd1, 4'h3, 4'b0010, 1'b1, 4'b1110, 16'h8F31};
    tbl[9] = '{1'b0, 2'd0, 4'h0, 4'b1010, 1'b1, 4'b0100, 16'h8F31};

    // reset state
    do_reset();
    chk("rst_o_valid", {28'h0, o_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_outs", {16'h0, o3, o2, o1, o0}, 32'h0);

    // directed table
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].sel, tbl[i].dat, tbl[i].ordy);
      chk("tbl_in_ready", {31'h0, act_rdy}, {31'h0, tbl[i].exp_rdy});
      chk("tbl_o_valid", {28'h0, o_valid}, {28'h0, tbl[i].exp_vld});
      chk("tbl_outs", {16'h0, o3, o2, o1, o0}, {16'h0, tbl[i].exp_o});
    end

    // streaming through slot 1 with its consumer always ready
    for (int w = 1; w <= 5; w++) begin
      step(1'b1, 2'd1, 4'(w), 4'b0010);
      chk("stream_in_ready", {31'h0, act_rdy}, 32'h1);
      chk("stream_o1", {28'h0, o1}, 32'(w));
      chk("stream_vld1", {31'h0, o_valid[1]}, 32'h1);
    end

    // random traffic against the model
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom));

    // mid-run reset with o_valid = 1011
    do_reset();
    step(1'b1, 2'd0, 4'h9, 4'b0000);
    step(1'b1, 2'd1, 4'hA, 4'b0000);
    step(1'b1, 2'd3, 4'hB, 4'b0000);
    chk("pre_rst_vld", {28'h0, o_valid}, 32'hB);
    #2;
    rst_b = 1'b0;
    #1;
    chk("async_rst_vld", {28'h0, o_valid}, 32'h0);
    chk("async_rst_outs", {16'h0, o3, o2, o1, o0}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_b = 1'b1;
    step(1'b1, 2'd2, 4'h5, 4'b0000);
    chk("post_rst_vld", {28'h0, o_valid}, 32'h4);

`ifdef DEMUX_CNT_EN
    // 257 deliveries through slot 0: counter wraps to 1
    do_reset();
    for (int i = 0; i < 257; i++)
      step(1'b1, 2'd0, 4'($urandom), 4'b0001);
    step(1'b0, 2'd0, 4'h0, 4'b0001);
    chk("cnt_wrap", cnt_flat, 32'h0000_0001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
